gap_argmax_classifier: RTL and testbench
========================================

Name: gap_argmax_classifier

Overview:
- Final classification stage, directly downstream of the 8x8 global-average-pooling stage.
- Consumes one IEEE-754 single-precision value per channel/class from the pooling stage's valid-qualified stream.
- Tracks the running maximum over NUM_CLASS consecutive values and emits the winning class index with a one-cycle valid pulse.
- Float comparison is done on bit patterns; no floating-point arithmetic unit is instantiated.

Parameters:
- DATA_WIDTH, 32, element width; IEEE-754 single only, other values unsupported.
- NUM_CLASS, 10, elements per frame; legal range 2..256.
- IDX_WIDTH, 4, class-index width; must satisfy 2^IDX_WIDTH >= NUM_CLASS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  pxl_in carries a valid element this cycle.
- pxl_in  in  DATA_WIDTH  float32 pooled value.
- frame_abort  in  1  synchronous discard of the partial frame.
- class_idx  out  IDX_WIDTH  index of the maximum element of the last completed frame.
- valid_out  out  1  one-cycle pulse: class_idx has been updated.
- busy  out  1  high while a frame is partially received.
- all_nan  out  1  last completed frame contained only NaNs.

Behaviour:
- Reset (reset low, async) clears:
  - class_idx=0, valid_out=0, busy=0, all_nan=0;
  - element counter=0, running max and its index, the have_max flag.
- Element counter counts 0..NUM_CLASS-1. Element k is the k-th valid_in of the frame and gets index k.
- Comparison key:
  - -0.0 (0x80000000) is normalized to +0.0 first.
  - key = sign ? ~x : (x ^ 0x80000000).
  - Unsigned key compare gives the total order -inf < negatives < 0 < positives < +inf.
- NaN (exp all ones, mantissa nonzero):
  - never becomes the maximum; it is skipped;
  - it still consumes an index.
- Update rule:
  - If have_max=0 and the element is not NaN, load it and set have_max=1.
  - Otherwise replace only when the new key is strictly greater. Ties keep the lowest index.
- Frame completion, i.e. a valid element at count NUM_CLASS-1 in cycle t. At clock edge t+1 (1-cycle latency) the block:
  - registers class_idx, including the comparison against the final element itself;
  - raises valid_out for exactly one cycle;
  - sets all_nan=!have_max_final (class_idx=0 in that case);
  - resets the counter, have_max and busy.
- Back-to-back frames: a valid_in in the cycle valid_out is high is element 0 of the next frame. No bubble is required.
- class_idx and all_nan hold until the next completion or reset.
- busy = (counter != 0) || have_max_pending. It rises the cycle after element 0 and falls the cycle after the last element.
- frame_abort high at an edge:
  - counter, have_max and busy are cleared;
  - valid_in in the same cycle is ignored;
  - class_idx, all_nan and valid_out are unaffected, with no pulse.
  - If frame_abort coincides with the last element, abort wins and no pulse is produced.
- valid_in low: no state change. Gaps of any length between elements are legal.
- Reset asserted mid-frame discards the frame. The first valid_in after reset release is element 0.
- No backpressure: the block accepts one element every cycle.

Optional Feature:
- Macro ARGMAX_MAXVAL_OUT_EN.
- Defined:
  - adds output port max_val (DATA_WIDTH), registered alongside class_idx;
  - max_val carries the original bit pattern of the winning element, so a -0.0 winner is reported as 0x80000000;
  - all_nan frame gives max_val=0x7FC00000;
  - reset value 0.
- Not defined: the port and its register are absent. All other behaviour is identical.

Test Plan:
- NUM_CLASS=10, values 1.0(0x3F800000) everywhere except index 6=2.0(0x40000000), contiguous valid_in → valid_out pulse 1 cycle after element 9, class_idx=6, all_nan=0.
- All values -3.0(0xC0400000) except index 3=-0.5(0xBF000000) and index 8=-0.0(0x80000000) → class_idx=8; with ARGMAX_MAXVAL_OUT_EN, max_val=0x80000000.
- Index 2 and 5 both +inf(0x7F800000), rest 0.5, with random valid_in gaps → class_idx=2 (lowest index on tie).
- Index 0=NaN(0x7FC00000), index 4=1.0, rest -1.0 → class_idx=4. Frame of all NaN → class_idx=0, all_nan=1.
- Two back-to-back frames, second starting in the valid_out cycle, maxima at 7 then 1 → pulses exactly 10 cycles apart, class_idx 7 then 1.
- Abort and reset recovery:
  - 5 elements, frame_abort, then full frame with max at 9 → one pulse only, class_idx=9.
  - Repeat with reset low mid-frame instead of frame_abort → outputs zero immediately (async); the next full frame is counted from element 0.

Source files
------------

// File: rtl/gap_argmax_classifier.sv
// Float32 argmax over NUM_CLASS pooled values, one per valid_in; emits class index pulse.
// Ports: clk, reset(async low), valid_in, pxl_in, frame_abort -> class_idx, valid_out, busy, all_nan[, max_val with ARGMAX_MAXVAL_OUT_EN].
module gap_argmax_classifier #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CLASS  = 10,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  frame_abort,
  output logic [IDX_WIDTH-1:0]  class_idx,
  output logic                  valid_out,
  output logic                  busy,
`ifdef ARGMAX_MAXVAL_OUT_EN
  output logic [DATA_WIDTH-1:0] max_val,
`endif
  output logic                  all_nan
);

  localparam logic [DATA_WIDTH-1:0] SIGN_BIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

  logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  have_q, have_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [IDX_WIDTH-1:0]  cls_q, cls_d;
  logic                  vld_q, vld_d;
  logic                  nan_q, nan_d;

  logic [DATA_WIDTH-1:0] norm;
  logic [DATA_WIDTH-1:0] key;
  logic                  is_nan;
  logic                  take;
  logic                  last;
  logic                  win_have;
  logic [IDX_WIDTH-1:0]  win_idx;

`ifdef ARGMAX_MAXVAL_OUT_EN
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic [DATA_WIDTH-1:0] mv_q, mv_d;
  logic [DATA_WIDTH-1:0] win_val;
`endif

  // -0.0 folds onto +0.0 so both share one key; the flip maps
  // sign-magnitude floats onto an unsigned monotonic order.
  assign norm   = (pxl_in == SIGN_BIT) ? '0 : pxl_in;
  assign key    = norm[DATA_WIDTH-1] ? ~norm : (norm ^ SIGN_BIT);
  assign is_nan = (&pxl_in[30:23]) && (|pxl_in[22:0]);
  assign take   = !is_nan && (!have_q || (key > key_q));
  assign last   = (cnt_q == LAST_IDX);

  assign win_have = have_q || !is_nan;
  assign win_idx  = take ? cnt_q : idx_q;
`ifdef ARGMAX_MAXVAL_OUT_EN
  assign win_val  = take ? pxl_in : val_q;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    have_d = have_q;
    key_d  = key_q;
    idx_d  = idx_q;
    cls_d  = cls_q;
    vld_d  = 1'b0;
    nan_d  = nan_q;
`ifdef ARGMAX_MAXVAL_OUT_EN
    val_d  = val_q;
    mv_d   = mv_q;
`endif
    if (frame_abort) begin
      cnt_d  = '0;
      have_d = 1'b0;
    end else if (valid_in) begin
      if (last) begin
        cnt_d  = '0;
        have_d = 1'b0;
        vld_d  = 1'b1;
        nan_d  = !win_have;
        cls_d  = win_have ? win_idx : '0;
`ifdef ARGMAX_MAXVAL_OUT_EN
        mv_d   = win_have ? win_val : 32'h7FC0_0000;
`endif
      end else begin
        cnt_d  = cnt_q + 1'b1;
        have_d = win_have;
        if (take) begin
          key_d = key;
          idx_d = cnt_q;
`ifdef ARGMAX_MAXVAL_OUT_EN
          val_d = pxl_in;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      have_q <= 1'b0;
      key_q  <= '0;
      idx_q  <= '0;
      cls_q  <= '0;
      vld_q  <= 1'b0;
      nan_q  <= 1'b0;
`ifdef ARGMAX_MAXVAL_OUT_EN
      val_q  <= '0;
      mv_q   <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      have_q <= have_d;
      key_q  <= key_d;
      idx_q  <= idx_d;
      cls_q  <= cls_d;
      vld_q  <= vld_d;
      nan_q  <= nan_d;
`ifdef ARGMAX_MAXVAL_OUT_EN
      val_q  <= val_d;
      mv_q   <= mv_d;
`endif
    end
  end

  assign class_idx = cls_q;
  assign valid_out = vld_q;
  assign all_nan   = nan_q;
  assign busy      = (cnt_q != '0) || have_q;
`ifdef ARGMAX_MAXVAL_OUT_EN
  assign max_val   = mv_q;
`endif

endmodule

// File: tb/tb_gap_argmax_classifier.sv
// Randomized + directed bench for gap_argmax_classifier.
// Reference: sign-magnitude arithmetic argmax over each frame.
module tb_gap_argmax_classifier;

  typedef logic [31:0] frame_t [10];

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] pxl_in;
  logic        frame_abort;
  logic [3:0]  class_idx;
  logic        valid_out;
  logic        busy;
  logic        all_nan;
`ifdef ARGMAX_MAXVAL_OUT_EN
  logic [31:0] max_val;
`endif

  int errors;
  int checks;
  int cyc;
  int last_cyc;
  int pcyc[$];
  int pidx[$];

  gap_argmax_classifier dut (
    .clk         (clk),
    .reset       (rst_n),
    .valid_in    (valid_in),
    .pxl_in      (pxl_in),
    .frame_abort (frame_abort),
    .class_idx   (class_idx),
    .valid_out   (valid_out),
    .busy        (busy),
`ifdef ARGMAX_MAXVAL_OUT_EN
    .max_val     (max_val),
`endif
    .all_nan     (all_nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out) begin
      pcyc.push_back(cyc);
      pidx.push_back(int'(class_idx));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic longint fval(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic int ref_idx(input frame_t v);
    int best;
    best = -1;
    for (int i = 0; i < 10; i++) begin
      if (!is_nan(v[i])) begin
        if (best < 0) best = i;
        else if (fval(v[i]) > fval(v[best])) best = i;
      end
    end
    return best;
  endfunction

  task automatic send_frame(input frame_t v, input int maxgap);
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        @(negedge clk);
        valid_in = 1'b0;
      end
      @(negedge clk);
      if (i == 1) chk("busy_mid", busy, 1);
      valid_in = 1'b1;
      pxl_in   = v[i];
      if (i == 9) last_cyc = cyc;
    end
  endtask

  task automatic check_frame(input string tag, input frame_t v,
                             input int npulse);
    int b;
    int e_idx;
    b = ref_idx(v);
    e_idx = (b < 0) ? 0 : b;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    chk({tag, "_npulse"}, pcyc.size(), npulse);
    if (pcyc.size() > 0) begin
      chk({tag, "_lat"}, pcyc[$] - last_cyc, 1);
      chk({tag, "_pidx"}, pidx[$], e_idx);
    end
    chk({tag, "_idx"}, class_idx, e_idx);
    chk({tag, "_nan"}, all_nan, (b < 0));
    chk({tag, "_vout"}, valid_out, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef ARGMAX_MAXVAL_OUT_EN
    chk({tag, "_mval"}, max_val, (b < 0) ? 32'h7FC0_0000 : v[b]);
`endif
  endtask

  task automatic clr_q();
    pcyc.delete();
    pidx.delete();
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = {r[31], 8'hFF, 1'b1, r[21:0]};
      1: r = 32'h8000_0000;
      2: r = 32'h0000_0000;
      3: r = 32'h7F80_0000;
      4: r = 32'hFF80_0000;
      default: ;
    endcase
    return r;
  endfunction

  frame_t f;
  frame_t g;

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    last_cyc = 0;
    rst_n = 1'b0;
    valid_in = 1'b0;
    pxl_in = '0;
    frame_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idx", class_idx, 0);
    chk("rst_vout", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nan", all_nan, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // max 2.0 at index 6, contiguous
    clr_q();
    foreach (f[i]) f[i] = 32'h3F80_0000;
    f[6] = 32'h4000_0000;
    send_frame(f, 0);
    check_frame("t1", f, 1);
    chk("t1_const", class_idx, 6);

    // -0.0 beats -0.5 and -3.0
    clr_q();
    foreach (f[i]) f[i] = 32'hC040_0000;
    f[3] = 32'hBF00_0000;
    f[8] = 32'h8000_0000;
    send_frame(f, 0);
    check_frame("t2", f, 1);
    chk("t2_const", class_idx, 8);

    // +inf tie, gaps
    clr_q();
    foreach (f[i]) f[i] = 32'h3F00_0000;
    f[2] = 32'h7F80_0000;
    f[5] = 32'h7F80_0000;
    send_frame(f, 3);
    check_frame("t3", f, 1);
    chk("t3_const", class_idx, 2);

    // NaN at 0 skipped
    clr_q();
    foreach (f[i]) f[i] = 32'hBF80_0000;
    f[0] = 32'h7FC0_0000;
    f[4] = 32'h3F80_0000;
    send_frame(f, 1);
    check_frame("t4", f, 1);
    chk("t4_const", class_idx, 4);

    // back-to-back, maxima 7 then 1
    clr_q();
    foreach (f[i]) f[i] = 32'h3F80_0000;
    f[7] = 32'h4100_0000;
    foreach (g[i]) g[i] = 32'hC000_0000;
    g[1] = 32'h3E00_0000;
    send_frame(f, 0);
    send_frame(g, 0);
    check_frame("b2b", g, 2);
    if (pcyc.size() == 2) begin
      chk("b2b_gap", pcyc[1] - pcyc[0], 10);
      chk("b2b_first", pidx[0], 7);
    end

    // all NaN
    clr_q();
    foreach (f[i]) f[i] = {1'b0, 8'hFF, 23'(i + 1)};
    send_frame(f, 1);
    check_frame("nan", f, 1);
    chk("nan_const", all_nan, 1);

    // abort after 5 elements
    clr_q();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      pxl_in = 32'h4200_0000;
    end
    @(negedge clk);
    frame_abort = 1'b1;
    pxl_in = 32'h7F80_0000;
    @(negedge clk);
    frame_abort = 1'b0;
    valid_in = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hold", all_nan, 1);
    foreach (f[i]) f[i] = 32'h3F80_0000;
    f[9] = 32'h4040_0000;
    send_frame(f, 0);
    check_frame("abort", f, 1);
    chk("abort_const", class_idx, 9);

    // async reset mid-frame
    clr_q();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_in = 1'b1;
      pxl_in = 32'h4200_0000;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_idx", class_idx, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n = 1'b1;
    foreach (f[i]) f[i] = 32'hBF80_0000;
    f[3] = 32'h3F80_0000;
    send_frame(f, 0);
    check_frame("arst", f, 1);

    // random frames
    for (int k = 0; k < 8; k++) begin
      clr_q();
      foreach (f[i]) f[i] = rnd_val();
      send_frame(f, 2);
      check_frame($sformatf("rnd%0d", k), f, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
